// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings and multiplier controller state type.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mul_ctrl_if.sv
// Start/busy/done handshake and operand/product bus of the multiplier.
interface alu_mul_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                      start;
    logic [DATA_WIDTH-1:0]     op_a;
    logic [DATA_WIDTH-1:0]     op_b;
    logic                      busy;
    logic                      done;
    logic [2*DATA_WIDTH-1:0]   product;

    modport master (
        output start, op_a, op_b,
        input  busy, done, product
    );

    modport slave (
        input  start, op_a, op_b,
        output busy, done, product
    );
endinterface

// File: rtl/alu.sv
// Combinational ALU: AND, OR, ADD, SUB, SLT selected by ALUop; ALUop[2] inverts B and sets carry-in.
module alu #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [2:0]            ALUop,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  CarryOut,
    output logic                  Overflow,
    output logic                  Zero
);
    logic [DATA_WIDTH-1:0] b_eff;
    logic [DATA_WIDTH:0]   sum;
    logic                  less;

    always_comb begin
        b_eff    = ALUop[2] ? ~B : B;
        sum      = {1'b0, A} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, ALUop[2]};
        CarryOut = sum[DATA_WIDTH];
        Overflow = (A[DATA_WIDTH-1] == b_eff[DATA_WIDTH-1]) &&
                   (sum[DATA_WIDTH-1] != A[DATA_WIDTH-1]);
        less     = sum[DATA_WIDTH-1] ^ Overflow;
        case (ALUop[1:0])
            2'b00:   Result = A & B;
            2'b01:   Result = A | B;
            2'b10:   Result = sum[DATA_WIDTH-1:0];
            default: Result = {{(DATA_WIDTH-1){1'b0}}, less};
        endcase
        Zero = (Result == '0);
    end
endmodule

// File: rtl/alu_mul_ctrl.sv
// Multi-cycle unsigned shift-add multiplier sequencing one shared combinational alu.
module alu_mul_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    alu_mul_ctrl_if.slave  bus
);
    localparam int unsigned       CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    state_t                    state_q;
    logic [DATA_WIDTH-1:0]     mcand_q;
    logic [DATA_WIDTH-1:0]     acc_hi_q, acc_hi_d;
    logic [DATA_WIDTH-1:0]     acc_lo_q, acc_lo_d;
    logic [CNT_W-1:0]          cnt_q;
    logic                      busy_q;
    logic                      done_q;
    logic [2*DATA_WIDTH-1:0]   product_q;

    logic [DATA_WIDTH-1:0]     alu_a, alu_b, alu_res;
    logic [2:0]                alu_op;
    logic                      alu_carry;
    logic                      alu_ovf_unused;
    logic                      alu_zero_unused;
    logic                      fast_path;

    alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .A        (alu_a),
        .B        (alu_b),
        .ALUop    (alu_op),
        .Result   (alu_res),
        .CarryOut (alu_carry),
        .Overflow (alu_ovf_unused),
        .Zero     (alu_zero_unused)
    );

    // ALU inputs are held at zero/AND outside CALC so the datapath stays quiet.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = ALU_AND;
        if (state_q == S_CALC) begin
            alu_a  = acc_hi_q;
            alu_b  = mcand_q;
            alu_op = ALU_ADD;
        end
        if (acc_lo_q[0]) begin
            {acc_hi_d, acc_lo_d} = {alu_carry, alu_res, acc_lo_q[DATA_WIDTH-1:1]};
        end else begin
            {acc_hi_d, acc_lo_d} = {1'b0, acc_hi_q, acc_lo_q[DATA_WIDTH-1:1]};
        end
        fast_path = (bus.op_a == '0) || (bus.op_b == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        if (fast_path) begin
                            product_q <= '0;
                            done_q    <= 1'b1;
                            state_q   <= S_DONE;
                        end else begin
                            mcand_q  <= bus.op_a;
                            acc_hi_q <= '0;
                            acc_lo_q <= bus.op_b;
                            cnt_q    <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= S_CALC;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_CALC: begin
                    acc_hi_q <= acc_hi_d;
                    acc_lo_q <= acc_lo_d;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        product_q <= {acc_hi_d, acc_lo_d};
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
endmodule
